dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//   Responder on the processor's data-memory port (address/data/wren in, q out).
//   Stands in for the dmem syncram and adds a memory-mapped I/O page.
//   Low addresses decode to an internal word RAM; the top page decodes to GPIO,
//   a cycle counter and a compare timer.
//   Read timing is identical to the syncram it replaces, so the processor needs no change.
// PARAMETERS
//   ADDR_W     12       word-address width of the dmem port
//   RAM_DEPTH  1024     words of internal RAM, mapped at 0 .. RAM_DEPTH-1
//   MMIO_BASE  12'hFF0  first word address of the 16-word MMIO page
// PORTS
//   clock         in   1       the dmem clock (dmem_clock); all state changes on its rising edge
//   reset         in   1       synchronous, active-high
//   address       in   ADDR_W  word address from processor
//   data          in   32      store data from processor
//   wren          in   1       store enable; address/data sampled on same edge
//   q             out  32      registered read data
//   gpio_out      out  32      GPIO output register
//   timer_irq     out  1       timer status AND irq-enable
//   decode_err    out  1       one-cycle pulse on access to an unmapped address
// BEHAVIOUR
//   Reset values
//   - q=0, gpio_out=0, CYCLE=0, TCTRL=0, TCMP=0, TCNT=0, TSTAT=0, decode_err=0.
//   - RAM contents are not reset.
//   Read timing
//   - q is loaded on edge N with the value addressed at edge N; it is valid through edge N+1.
//   - q updates every edge, whether or not wren is asserted.
//   Read-during-write
//   - q returns the pre-write value (old data) for both RAM and MMIO.
//   Address map
//   - addr < RAM_DEPTH: RAM.
//   - MMIO_BASE+0 GPIO (RW).
//   - +1 CYCLE (RO): free-running 32-bit count, wraps FFFF_FFFF->0.
//   - +2 TCTRL (RW): bit0 = timer enable, bit1 = irq enable; bits 31:2 read 0.
//   - +3 TCMP (RW).
//   - +4 TCNT (RO).
//   - +5 TSTAT (W1C): bit0 = expired; bits 31:1 read 0.
//   - Any other address: reads 0, writes ignored; decode_err=1 on the next cycle, one cycle wide.
//   - Writes to RO registers are ignored and are NOT decode errors.
//   Timer
//   - When TCTRL[0]=1 and TCMP!=0: TCNT increments each cycle.
//   - When TCNT==TCMP-1 at an edge: TCNT<=0 and TSTAT[0]<=1.
//   - When TCTRL[0]=0: TCNT holds.
//   - A write to TCMP or TCTRL also clears TCNT to 0.
//   - Set and W1C of TSTAT[0] on the same edge: set wins.
//   - timer_irq = TSTAT[0] & TCTRL[1], combinational from registers.
//   Reset mid-operation
//   - A store coinciding with reset is dropped for all targets (RAM and MMIO).
//   - q=0 on the edge after reset.
// TESTING
//   1. Store A5A5_0001 @0x010, then read @0x010 -> q=A5A5_0001 one edge after the read address; q=0 during reset.
//   2. Store 1 @0x020, then same-edge store 2 + read @0x020 -> q=1; next read -> q=2.
//   3. Read CYCLE twice, 5 cycles apart -> difference=5; preload via force to FFFF_FFFE, step 3 -> reads 1.
//   4. TCMP=4, TCTRL=3 -> TSTAT[0] and timer_irq rise exactly 4 cycles after the TCTRL write;
//      W1C clears; W1C on the expiry edge leaves TSTAT=1.
//   5. Read @0x800 (RAM_DEPTH=1024) -> q=0 and decode_err single pulse;
//      store @MMIO_BASE+1 -> CYCLE unaffected, no decode_err.
//   6. Store GPIO=DEAD_BEEF, assert reset 1 cycle -> gpio_out=0, TCTRL=0, timer_irq=0; RAM@0x010 retains data.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: internal word RAM plus a 16-word MMIO page
// holding GPIO, a free-running cycle counter and a compare timer.
// Read timing matches a syncram: q is registered from the address at the same edge.
module dmem_mmio_responder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(12'hFF0)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q,
    output logic [31:0]       gpio_out,
    output logic              timer_irq,
    output logic              decode_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned PAGE_W = 4;

    localparam logic [PAGE_W-1:0] OFF_GPIO  = PAGE_W'(0);
    localparam logic [PAGE_W-1:0] OFF_CYCLE = PAGE_W'(1);
    localparam logic [PAGE_W-1:0] OFF_TCTRL = PAGE_W'(2);
    localparam logic [PAGE_W-1:0] OFF_TCMP  = PAGE_W'(3);
    localparam logic [PAGE_W-1:0] OFF_TCNT  = PAGE_W'(4);
    localparam logic [PAGE_W-1:0] OFF_TSTAT = PAGE_W'(5);

    // RAM storage and read path
    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [DATA_W-1:0] ram_rd;
    logic [RAM_AW-1:0] ram_idx;

    // MMIO registers
    logic [DATA_W-1:0] cycle_cnt;
    logic [DATA_W-1:0] gpio_reg;
    logic [1:0]        tctrl;
    logic [DATA_W-1:0] tcmp;
    logic [DATA_W-1:0] tcnt;
    logic              tstat;

    // Read-data staging
    logic              rd_sel_ram;
    logic [DATA_W-1:0] mmio_q;
    logic [DATA_W-1:0] mmio_rdata;

    // Decode results
    logic              hit_ram;
    logic              hit_page;
    logic [PAGE_W-1:0] offset;
    logic              hit_mmio;
    logic              unmapped;

    // Write strobes
    logic wr_ok;
    logic wr_ram;
    logic wr_gpio;
    logic wr_tctrl;
    logic wr_tcmp;
    logic wr_tstat;
    logic cfg_wr;

    // Timer controls
    logic timer_run;
    logic timer_hit;

    // Address decode: RAM takes priority if it ever overlaps the MMIO page
    always_comb begin
        hit_ram  = 32'(address) < 32'(RAM_DEPTH);
        hit_page = address[ADDR_W-1:PAGE_W] == MMIO_BASE[ADDR_W-1:PAGE_W];
        offset   = address[PAGE_W-1:0];
        hit_mmio = !hit_ram && hit_page && (offset <= OFF_TSTAT);
        unmapped = !hit_ram && !hit_mmio;
        ram_idx  = address[RAM_AW-1:0];
    end

    // Store strobes; a store coinciding with reset is dropped everywhere
    always_comb begin
        wr_ok    = wren && !reset;
        wr_ram   = wr_ok && hit_ram;
        wr_gpio  = wr_ok && hit_mmio && (offset == OFF_GPIO);
        wr_tctrl = wr_ok && hit_mmio && (offset == OFF_TCTRL);
        wr_tcmp  = wr_ok && hit_mmio && (offset == OFF_TCMP);
        wr_tstat = wr_ok && hit_mmio && (offset == OFF_TSTAT);
        cfg_wr   = wr_tctrl || wr_tcmp;
    end

    // Timer enable and expiry; a config write restarts the count instead of expiring
    always_comb begin
        timer_run = tctrl[0] && (tcmp != '0);
        timer_hit = timer_run && !cfg_wr && (tcnt == tcmp - DATA_W'(1));
    end

    // MMIO read mux from current register values (gives old data on read-during-write)
    always_comb begin
        mmio_rdata = '0;
        if (hit_mmio) begin
            unique case (offset)
                OFF_GPIO:  mmio_rdata = gpio_reg;
                OFF_CYCLE: mmio_rdata = cycle_cnt;
                OFF_TCTRL: mmio_rdata = {30'(0), tctrl};
                OFF_TCMP:  mmio_rdata = tcmp;
                OFF_TCNT:  mmio_rdata = tcnt;
                OFF_TSTAT: mmio_rdata = {31'(0), tstat};
                default:   mmio_rdata = '0;
            endcase
        end
    end

    // Word RAM: synchronous write, synchronous read of pre-write contents, never reset
    always_ff @(posedge clock) begin
        if (wr_ram) begin
            mem[ram_idx] <= data;
        end
        ram_rd <= mem[ram_idx];
    end

    // Read-path select and MMIO read register
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_sel_ram <= 1'b0;
            mmio_q     <= '0;
        end else begin
            rd_sel_ram <= hit_ram;
            mmio_q     <= hit_ram ? '0 : mmio_rdata;
        end
    end

    // Final read data: both sources are registers, selected by a registered flag
    assign q = rd_sel_ram ? ram_rd : mmio_q;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + DATA_W'(1);
        end
    end

    // GPIO output register
    always_ff @(posedge clock) begin
        if (reset) begin
            gpio_reg <= '0;
        end else if (wr_gpio) begin
            gpio_reg <= data;
        end
    end

    assign gpio_out = gpio_reg;

    // Compare timer: control, compare, count and sticky expiry status
    always_ff @(posedge clock) begin
        if (reset) begin
            tctrl <= '0;
            tcmp  <= '0;
            tcnt  <= '0;
            tstat <= 1'b0;
        end else begin
            if (wr_tctrl) begin
                tctrl <= data[1:0];
            end
            if (wr_tcmp) begin
                tcmp <= data;
            end
            if (cfg_wr || timer_hit) begin
                tcnt <= '0;
            end else if (timer_run) begin
                tcnt <= tcnt + DATA_W'(1);
            end
            if (timer_hit) begin
                tstat <= 1'b1;
            end else if (wr_tstat && data[0]) begin
                tstat <= 1'b0;
            end
        end
    end

    assign timer_irq = tstat & tctrl[1];

    // One-cycle flag for each access that hits no mapped location
    always_ff @(posedge clock) begin
        if (reset) begin
            decode_err <= 1'b0;
        end else begin
            decode_err <= unmapped;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: stimulus queues expected output
// values tagged with the cycle they must appear in; a monitor checks them.
module tb_dmem_mmio_responder;

    localparam int W_Q    = 0;
    localparam int W_GPIO = 1;
    localparam int W_IRQ  = 2;
    localparam int W_DERR = 3;

    localparam logic [11:0] A_GPIO  = 12'hFF0;
    localparam logic [11:0] A_CYCLE = 12'hFF1;
    localparam logic [11:0] A_TCTRL = 12'hFF2;
    localparam logic [11:0] A_TCMP  = 12'hFF3;
    localparam logic [11:0] A_TCNT  = 12'hFF4;
    localparam logic [11:0] A_TSTAT = 12'hFF5;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        decode_err;

    dmem_mmio_responder dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .q          (q),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq),
        .decode_err (decode_err)
    );

    always #5 clock = ~clock;

    // posedge count; the negedge after edge k sees cyc == k
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          what;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // cycle-counter model: value held after edge k
    logic [31:0] cyc_val0 = 32'd0;
    int          cyc_base = 0;

    function automatic logic [31:0] cyc_model();
        return cyc_val0 + 32'(cyc - cyc_base);
    endfunction

    function automatic logic [31:0] sample(input int what);
        case (what)
            W_Q:    return q;
            W_GPIO: return gpio_out;
            W_IRQ:  return {31'd0, timer_irq};
            default: return {31'd0, decode_err};
        endcase
    endfunction

    task automatic expect_in(input int k, input int what, input logic [31:0] v, input string n);
        exp_t e;
        e.at = cyc + k;
        e.what = what;
        e.val = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [11:0] a, input logic w, input logic [31:0] d);
        address = a;
        wren = w;
        data = d;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_until(input int target);
        drive(12'h000, 1'b0, 32'd0);
        while (cyc < target) @(negedge clock);
    endtask

    // Monitor: compare every entry due this cycle, flag any that slipped past
    always @(negedge clock) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                checks++;
                act = sample(sb[i].what);
                if (sb[i].at < cyc) begin
                    failures++;
                    $display("FAIL %s: not sampled at cycle %0d (now %0d)", sb[i].name, sb[i].at, cyc);
                end else if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [31:0] v_a;

        reset = 1'b1;
        drive(12'h000, 1'b0, 32'd0);

        // reset state
        expect_in(1, W_Q,    32'd0, "rst_q");
        expect_in(1, W_GPIO, 32'd0, "rst_gpio");
        expect_in(1, W_IRQ,  32'd0, "rst_irq");
        expect_in(1, W_DERR, 32'd0, "rst_derr");
        tick();
        drive(12'h010, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd0, "rst_q_during_read");
        tick();
        tick();
        reset = 1'b0;
        cyc_base = cyc;
        cyc_val0 = 32'd0;

        // 1: store then read back with one-edge latency
        drive(12'h010, 1'b1, 32'hA5A5_0001);
        tick();
        drive(12'h010, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'hA5A5_0001, "t1_read");
        tick();

        // 2: read-during-write returns old data
        drive(12'h020, 1'b1, 32'd1);
        tick();
        drive(12'h020, 1'b1, 32'd2);
        expect_in(1, W_Q, 32'd1, "t2_rdw_old");
        tick();
        drive(12'h020, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd2, "t2_new");
        tick();

        // 3: cycle counter spacing and wrap
        v_a = cyc_model();
        drive(A_CYCLE, 1'b0, 32'd0);
        expect_in(1, W_Q, v_a, "t3_cycle_a");
        tick();
        idle_until(cyc + 4);
        drive(A_CYCLE, 1'b0, 32'd0);
        expect_in(1, W_Q, v_a + 32'd5, "t3_cycle_diff5");
        tick();
        drive(12'h000, 1'b0, 32'd0);
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        cyc_base = cyc;
        cyc_val0 = 32'hFFFF_FFFE;
        #1 release dut.cycle_cnt;
        tick();
        tick();
        tick();
        drive(A_CYCLE, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd1, "t3_cycle_wrap");
        tick();

        // 4: compare timer expiry, W1C, set-wins
        drive(A_TCMP, 1'b1, 32'd4);
        tick();
        drive(A_TCTRL, 1'b1, 32'd3);
        c = cyc;
        expect_in(4, W_IRQ, 32'd0, "t4_irq_pre");
        expect_in(5, W_IRQ, 32'd1, "t4_irq_rise");
        tick();
        idle_until(c + 4);
        drive(A_TSTAT, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd0, "t4_tstat_pre");
        tick();
        drive(A_TSTAT, 1'b1, 32'd1);
        expect_in(1, W_Q, 32'd1, "t4_tstat_set");
        expect_in(1, W_IRQ, 32'd0, "t4_w1c_clears");
        tick();
        idle_until(c + 8);
        drive(A_TSTAT, 1'b1, 32'd1);
        expect_in(1, W_IRQ, 32'd1, "t4_set_wins");
        expect_in(1, W_Q, 32'd0, "t4_tstat_rdw_old");
        tick();
        drive(A_TCTRL, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd3, "t4_tctrl_read");
        tick();
        drive(A_TCNT, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd1, "t4_tcnt_read");
        tick();
        drive(A_TCTRL, 1'b1, 32'd0);
        tick();
        drive(A_TSTAT, 1'b1, 32'd1);
        tick();

        // 5: unmapped access and store to a read-only register
        drive(12'h800, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd0, "t5_unmapped_q");
        expect_in(1, W_DERR, 32'd1, "t5_derr");
        tick();
        drive(12'h010, 1'b0, 32'd0);
        expect_in(1, W_DERR, 32'd0, "t5_derr_one_cycle");
        expect_in(1, W_Q, 32'hA5A5_0001, "t5_ram_after_err");
        tick();
        drive(A_CYCLE, 1'b1, 32'h1234_5678);
        expect_in(1, W_DERR, 32'd0, "t5_ro_no_err");
        expect_in(1, W_Q, cyc_model(), "t5_ro_rdw");
        tick();
        drive(A_CYCLE, 1'b0, 32'd0);
        expect_in(1, W_Q, cyc_model(), "t5_cycle_unaffected");
        tick();

        // 6: reset mid-operation
        drive(A_TCMP, 1'b1, 32'd2);
        tick();
        drive(A_TCTRL, 1'b1, 32'd3);
        c = cyc;
        expect_in(3, W_IRQ, 32'd1, "t6_irq_armed");
        tick();
        drive(A_GPIO, 1'b1, 32'hDEAD_BEEF);
        expect_in(1, W_GPIO, 32'hDEAD_BEEF, "t6_gpio");
        tick();
        idle_until(c + 3);
        reset = 1'b1;
        drive(12'h010, 1'b1, 32'h0000_0BAD);
        expect_in(1, W_GPIO, 32'd0, "t6_gpio_rst");
        expect_in(1, W_IRQ, 32'd0, "t6_irq_rst");
        expect_in(1, W_Q, 32'd0, "t6_q_rst");
        tick();
        reset = 1'b0;
        cyc_base = cyc;
        cyc_val0 = 32'd0;
        drive(A_TCTRL, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'd0, "t6_tctrl_rst");
        tick();
        drive(12'h010, 1'b0, 32'd0);
        expect_in(1, W_Q, 32'hA5A5_0001, "t6_ram_kept");
        tick();
        drive(A_CYCLE, 1'b0, 32'd0);
        expect_in(1, W_Q, cyc_model(), "t6_cycle_rst");
        tick();

        idle_until(cyc + 3);
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
